// File: rtl/song_sequencer.sv
// song_sequencer: Ode to Joy autoplay driving the piano's one-hot key vector.
// Define SONG_LOOP_EN to repeat the song until stop/RESET instead of playing one pass.
module song_sequencer #(
  parameter logic [31:0] BEAT_DIV   = 32'd25_000_000,
  parameter logic [31:0] GAP_CYCLES = 32'd2_500_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] notes,
  output logic       busy,
  output logic       done,
  output logic [3:0] step
);
  typedef enum logic [1:0] {IDLE, SOUND, GAP} state_t;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  step_q, step_d;
  logic [7:0]  notes_q, notes_d;
  logic        busy_q, busy_d, done_q, done_d;
  // Note codes, C4=0 .. C5=7; entry 15 is padding so any 4-bit index is legal.
  localparam logic [2:0] NOTE_ROM [16] = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1,
                                           3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
  function automatic logic [31:0] note_load(input logic [3:0] s);
    logic [31:0] beats;
    beats = s < 4'd12 ? 32'd2 : s == 4'd12 ? 32'd3 : s == 4'd13 ? 32'd1 : 32'd4;
    return beats * BEAT_DIV - 32'd1;
  endfunction
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = 32'd0;
      step_d  = 4'd0;
    end else if (state_q == IDLE) begin
      if (start) begin
        state_d = SOUND;
        step_d  = 4'd0;
        cnt_d   = note_load(4'd0);
      end
    end else if (cnt_q != 32'd0) begin
      cnt_d = cnt_q - 32'd1;
    end else if (state_q == SOUND) begin
      state_d = GAP;
      cnt_d   = GAP_CYCLES - 32'd1;
    end else if (step_q != 4'd14) begin
      state_d = SOUND;
      step_d  = step_q + 4'd1;
      cnt_d   = note_load(step_q + 4'd1);
    end else begin
      done_d = 1'b1;
      step_d = 4'd0;
`ifdef SONG_LOOP_EN
      state_d = SOUND;
      cnt_d   = note_load(4'd0);
`else
      state_d = IDLE;
      cnt_d   = 32'd0;
`endif
    end
    notes_d = (state_d == SOUND) ? (8'h80 >> NOTE_ROM[step_d]) : 8'h00;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      step_q  <= 4'd0;
      notes_q <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      notes_q <= notes_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign notes = notes_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign step  = step_q;
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed and random start/stop/reset stimulus against a song-timeline model.
module tb_song_sequencer;
  localparam int BD = 4;
  localparam int GC = 2;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] notes;
  logic       busy, done;
  logic [3:0] step;
  int n_cmp = 0;
  int n_bad = 0;
  int dur_tbl [15] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 1, 4};
  int note_tbl [15] = '{2, 2, 3, 4, 4, 3, 2, 1, 0, 0, 1, 2, 2, 1, 1};
  bit playing;
  int t;
  bit done_e;
  int done_at;

  song_sequencer #(.BEAT_DIV(32'd4), .GAP_CYCLES(32'd2)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .stop(stop),
    .notes(notes), .busy(busy), .done(done), .step(step)
  );

  always #5 CLK = ~CLK;

  function automatic int pass_len();
    int s;
    s = 0;
    for (int i = 0; i < 15; i++) s += dur_tbl[i] * BD + GC;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    playing = 0;
    t = 0;
    done_e = 0;
  endtask

  // t counts cycles since the accepted start; t=1 is the first sounding cycle.
  task automatic model_edge(input bit s, input bit p);
    done_e = 0;
    if (p) begin
      playing = 0;
      t = 0;
    end else if (!playing) begin
      if (s) begin
        playing = 1;
        t = 1;
      end
    end else begin
      t++;
      if (t > pass_len()) begin
        done_e = 1;
`ifdef SONG_LOOP_EN
        t = 1;
`else
        playing = 0;
        t = 0;
`endif
      end
    end
  endtask

  task automatic check_all(input string ph);
    logic [7:0] en;
    logic [3:0] es;
    int o, len;
    en = 8'h00;
    es = 4'd0;
    if (playing) begin
      o = t - 1;
      for (int i = 0; i < 15; i++) begin
        len = dur_tbl[i] * BD;
        if (o >= 0 && o < len + GC) begin
          es = 4'(i);
          if (o < len) en = 8'h80 >> note_tbl[i];
        end
        o -= len + GC;
      end
    end
    chk({ph, ".notes"}, 32'(notes), 32'(en));
    chk({ph, ".busy"}, 32'(busy), 32'(playing));
    chk({ph, ".done"}, 32'(done), 32'(done_e));
    chk({ph, ".step"}, 32'(step), 32'(es));
  endtask

  task automatic cyc(input logic s, input logic p, input string ph);
    start = s;
    stop = p;
    @(posedge CLK);
    model_edge(s, p);
    @(negedge CLK);
    check_all(ph);
  endtask

  // Called at a negedge: reset lands mid-cycle, outputs must clear before any edge.
  task automatic async_reset();
    #2 RESET = 1'b1;
    #1 model_reset();
    check_all("areset");
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    bit held;
    model_reset();
    repeat (2) @(negedge CLK);
    check_all("reset");
    RESET = 1'b0;
    done_at = -1;
    for (int c = 0; c < 170; c++) begin
      cyc(c == 0 || c == 5 || c == 50, 1'b0, "pass");
      if (done === 1'b1 && done_at < 0) done_at = c + 1;
    end
    chk("done_cycle", 32'(done_at), 32'd159);
    cyc(1'b0, 1'b1, "idle");
    for (int c = 0; c < 40; c++) cyc(c == 0 || c == 25, c == 20, "stop");
    cyc(1'b0, 1'b1, "idle");
    for (int c = 0; c < 30; c++) cyc(c == 0, 1'b0, "pre_rst");
    async_reset();
    for (int c = 0; c < 10; c++) cyc(1'b0, 1'b0, "post_rst");
    for (int c = 0; c < 340; c++) cyc(1'b1, 1'b0, "held");
    cyc(1'b0, 1'b1, "idle");
    held = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) held = ~held;
      if ($urandom_range(0, 1499) == 0) async_reset();
      cyc(held || $urandom_range(0, 29) == 0, $urandom_range(0, 399) == 0, "rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
